video_pattern_gen: RTL and testbench
====================================

# video_pattern_gen

Parameterised AXI-Stream video source that generates synthetic frames (solid, ramps, checkerboard) with SOF on `tuser` and EOL on `tlast`. It sits directly upstream of the frame-rate counter stage and drives its input stream for bring-up and regression. It is also the stimulus source for row, line and frame-rate measurement.

## Interface
- `AXIS_DATA_WIDTH`, 24: pixel width in bits.
- `IMG_WIDTH_MAX`, 16: width of the column counter and `i_width`.
- `IMG_HEIGHT_MAX`, 16: width of the row counter and `i_height`.
- `GAP_WIDTH`, 16: width of `i_frame_gap`.

Ports:
- `i_axi_clk`, in, 1: single clock, rising edge.
- `i_axi_rst`, in, 1: asynchronous, active-low reset.
- `i_enable`, in, 1: run request (level).
- `i_width`, in, IMG_WIDTH_MAX: pixels per row. Latched at frame start.
- `i_height`, in, IMG_HEIGHT_MAX: rows per frame. Latched at frame start.
- `i_pattern`, in, 2: pattern select. Latched at frame start.
  - 0: solid
  - 1: horizontal ramp
  - 2: vertical ramp
  - 3: checker
- `i_color`, in, AXIS_DATA_WIDTH: solid colour for pattern 0.
- `i_frame_gap`, in, GAP_WIDTH: idle cycles between frames. Latched at frame end.
- `o_axis_out_tuser`, out, 1: start of frame.
- `o_axis_out_tvalid`, out, 1: beat valid.
- `i_axis_out_tready`, in, 1: sink ready.
- `o_axis_out_tlast`, out, 1: end of row.
- `o_axis_out_tdata`, out, AXIS_DATA_WIDTH: pixel data.
- `o_frame_done`, out, 1: one-cycle strobe per completed frame.
- `o_busy`, out, 1: high in ACTIVE or GAP.

## Operation
- **FSM states:** IDLE, ACTIVE, GAP.
- **IDLE → ACTIVE:** taken when `i_enable`=1 and `i_width`≠0 and `i_height`≠0.
  - On this transition, latch width, height and pattern.
  - Clear x and y to 0.
- **Zero geometry:** if width or height is 0, the block stays in IDLE with no output.
- **ACTIVE beat contents:**
  - `tuser` = (x==0 && y==0).
  - `tlast` = (x==width-1).
  - `tdata` = f(pattern, x, y).
- **Advance:** x and y advance only on a handshake (`tvalid && tready`).
  - x wraps to 0 at width-1, and y increments on that wrap.
- **Last beat:** the handshake on x==width-1, y==height-1 completes the frame.
  - `o_frame_done` pulses.
  - Load the gap counter with `i_frame_gap` and go to GAP.
- **GAP:**
  - `tvalid`=0; the counter decrements each cycle.
  - At 0: go to ACTIVE with freshly latched config if `i_enable`=1 and geometry is nonzero; otherwise go to IDLE.
  - A gap of 0 spends exactly 1 cycle in GAP.
- **Disable:** deasserting `i_enable` mid-frame never truncates a frame. The current frame completes, then the block returns to IDLE through GAP.
- **Patterns.** Values are zero-extended or truncated to AXIS_DATA_WIDTH.
  - 0: `i_color`, sampled live.
  - 1: x.
  - 2: y.
  - 3: all-ones if x[3]^y[3], else 0.
- **Config changes:** changes to `i_width`, `i_height` or `i_pattern` mid-frame have no effect until the next frame start.

## Timing
- **Reset values:** all outputs are 0 and the FSM is in IDLE.
  - Reset asserted mid-frame drops `tvalid` immediately (asynchronously). No partial frame resumes after release.
- **Start latency:** `i_enable` sampled high in IDLE → first beat (`tvalid`=1, `tuser`=1) on the next cycle.
- **Registered outputs:** all outputs are registered.
- **Stall rule:** while `tvalid`=1 and `tready`=0, `tdata`, `tuser` and `tlast` hold stable. `tvalid` never drops before the handshake.
- **Throughput:** with `tready` held high, one beat is sent per cycle. A frame occupies width×height cycles, followed by gap+1 idle cycles.
- **Frame done:** `o_frame_done` is high the cycle after the final handshake, coincident with the first GAP cycle.
- **Busy:** `o_busy`=1 from the cycle the first beat is presented until GAP exits to IDLE.

## Configuration
- **Macro:** `VIDEO_PATTERN_GEN_MOVING_EN`.
- **Defined:** an internal frame counter of IMG_WIDTH_MAX bits increments on each `o_frame_done` and wraps at 2^IMG_WIDTH_MAX.
  - Pattern 1 outputs x + frame_count, modulo 2^IMG_WIDTH_MAX (a scrolling ramp).
  - The counter is cleared by reset.
- **Undefined:** the frame counter is not built and pattern 1 is a static x ramp.
- All other behaviour is identical with and without the macro.

## Test plan
- **Basic frame:** width=4, height=3, pattern=1, gap=2, `tready`=1.
  - Required: 12 beats with tdata 0,1,2,3 repeated per row.
  - `tuser` on beat 0 only; `tlast` on beats 3, 7 and 11.
  - `o_frame_done` one cycle after beat 11, then 3 idle cycles, then next SOF.
- **Backpressure:** random `tready` at 50%.
  - Required: `tdata`, `tuser` and `tlast` stable during every stall.
  - Beat sequence identical to the `tready`=1 run.
  - No `tvalid` drop before a handshake.
- **Disable / config change mid-frame:**
  - Drop `i_enable` at beat 5 of a 4×3 frame: all 12 beats are still sent, then IDLE with `o_busy`=0.
  - Change `i_width` to 8 mid-frame: the current frame keeps width 4.
- **Zero geometry:** `i_height`=0 with `i_enable`=1.
  - Required: `tvalid` stays 0 and `o_busy` stays 0.
  - Setting `i_height`=2 starts a frame the next cycle.
- **Reset mid-frame:** assert `i_axi_rst`=0 at beat 6.
  - Required: `tvalid`=0 immediately.
  - After release with enable high, the next beat has `tuser`=1 and x=y=0.
- **Moving pattern (macro defined):** width=4, pattern=1.
  - Frame 2 row data = 1,2,3,4; frame 3 = 2,3,4,5.
  - Checker pattern on a 16×16 frame: pixel (8,0) = all-ones, pixel (8,8) = 0.

Source files
------------

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: AXI-Stream synthetic frame source (solid, ramps, checker) with SOF on tuser, EOL on tlast.
// Define VIDEO_PATTERN_GEN_MOVING_EN to scroll the horizontal ramp by one pixel per frame.
module video_pattern_gen #(
  parameter int AXIS_DATA_WIDTH = 24,
  parameter int IMG_WIDTH_MAX   = 16,
  parameter int IMG_HEIGHT_MAX  = 16,
  parameter int GAP_WIDTH       = 16
) (
  input  logic                       i_axi_clk,
  input  logic                       i_axi_rst,
  input  logic                       i_enable,
  input  logic [IMG_WIDTH_MAX-1:0]   i_width,
  input  logic [IMG_HEIGHT_MAX-1:0]  i_height,
  input  logic [1:0]                 i_pattern,
  input  logic [AXIS_DATA_WIDTH-1:0] i_color,
  input  logic [GAP_WIDTH-1:0]       i_frame_gap,
  output logic                       o_axis_out_tuser,
  output logic                       o_axis_out_tvalid,
  input  logic                       i_axis_out_tready,
  output logic                       o_axis_out_tlast,
  output logic [AXIS_DATA_WIDTH-1:0] o_axis_out_tdata,
  output logic                       o_frame_done,
  output logic                       o_busy
);
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
  state_t state, n_state;
  logic [IMG_WIDTH_MAX-1:0] x, nx, width_q, n_width, ramp_x;
  logic [IMG_HEIGHT_MAX-1:0] y, ny, height_q, n_height;
  logic [1:0] pattern_q, n_pattern;
  logic [GAP_WIDTH-1:0] gap_cnt, n_gap;
  logic [AXIS_DATA_WIDTH-1:0] n_data;
  logic hs, last_x, last_y, start_ok, done, load;
  assign hs       = o_axis_out_tvalid && i_axis_out_tready;
  assign last_x   = x == width_q - 1'b1;
  assign last_y   = y == height_q - 1'b1;
  assign start_ok = i_enable && |i_width && |i_height;
  // output beat registers only advance when the current beat is not stalled
  assign load     = !o_axis_out_tvalid || i_axis_out_tready;
  always_comb begin
    n_state   = state;
    nx        = x;
    ny        = y;
    n_width   = width_q;
    n_height  = height_q;
    n_pattern = pattern_q;
    n_gap     = gap_cnt;
    done      = 1'b0;
    if (state == ACTIVE) begin
      if (hs) begin
        nx = last_x ? '0 : x + 1'b1;
        ny = last_x ? y + 1'b1 : y;
        if (last_x && last_y) begin
          done    = 1'b1;
          n_gap   = i_frame_gap;
          n_state = GAP;
        end
      end
    end else if (state == IDLE || gap_cnt == '0) begin
      n_state = start_ok ? ACTIVE : IDLE;
      if (start_ok) begin
        nx        = '0;
        ny        = '0;
        n_width   = i_width;
        n_height  = i_height;
        n_pattern = i_pattern;
      end
    end else begin
      n_gap = gap_cnt - 1'b1;
    end
  end
`ifdef VIDEO_PATTERN_GEN_MOVING_EN
  logic [IMG_WIDTH_MAX-1:0] frame_cnt;
  always_ff @(posedge i_axi_clk or negedge i_axi_rst)
    if (!i_axi_rst) frame_cnt <= '0;
    else if (done) frame_cnt <= frame_cnt + 1'b1;
  assign ramp_x = nx + frame_cnt;
`else
  assign ramp_x = nx;
`endif
  assign n_data = n_state != ACTIVE ? '0 :
                  n_pattern == 2'd0 ? i_color :
                  n_pattern == 2'd1 ? AXIS_DATA_WIDTH'(ramp_x) :
                  n_pattern == 2'd2 ? AXIS_DATA_WIDTH'(ny) :
                  {AXIS_DATA_WIDTH{nx[3] ^ ny[3]}};
  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    if (!i_axi_rst) begin
      state             <= IDLE;
      x                 <= '0;
      y                 <= '0;
      width_q           <= '0;
      height_q          <= '0;
      pattern_q         <= '0;
      gap_cnt           <= '0;
      o_axis_out_tvalid <= 1'b0;
      o_axis_out_tuser  <= 1'b0;
      o_axis_out_tlast  <= 1'b0;
      o_axis_out_tdata  <= '0;
      o_frame_done      <= 1'b0;
      o_busy            <= 1'b0;
    end else begin
      state        <= n_state;
      x            <= nx;
      y            <= ny;
      width_q      <= n_width;
      height_q     <= n_height;
      pattern_q    <= n_pattern;
      gap_cnt      <= n_gap;
      o_frame_done <= done;
      o_busy       <= n_state != IDLE;
      if (load) begin
        o_axis_out_tvalid <= n_state == ACTIVE;
        o_axis_out_tuser  <= n_state == ACTIVE && nx == '0 && ny == '0;
        o_axis_out_tlast  <= n_state == ACTIVE && nx == n_width - 1'b1;
        o_axis_out_tdata  <= n_data;
      end
    end
  end
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: directed checks of video_pattern_gen framing, patterns, backpressure, gap and reset.
module tb_video_pattern_gen;
  logic clk, rst_n, en, tready;
  logic [15:0] width, height, gap;
  logic [1:0] pattern;
  logic [23:0] color;
  logic tuser, tvalid, tlast, done, busy;
  logic [23:0] tdata;
  int checks = 0, errors = 0, fc = 0;

  video_pattern_gen dut (
    .i_axi_clk(clk), .i_axi_rst(rst_n), .i_enable(en), .i_width(width), .i_height(height),
    .i_pattern(pattern), .i_color(color), .i_frame_gap(gap),
    .o_axis_out_tuser(tuser), .o_axis_out_tvalid(tvalid), .i_axis_out_tready(tready),
    .o_axis_out_tlast(tlast), .o_axis_out_tdata(tdata), .o_frame_done(done), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ramp(input int x);
    logic [15:0] v;
    v = 16'(x);
`ifdef VIDEO_PATTERN_GEN_MOVING_EN
    v = v + 16'(fc);
`endif
    return {16'h0, v};
  endfunction

  task automatic beat(input string tag, input logic [31:0] d, input logic u, input logic l);
    @(negedge clk);
    chk({tag, "_tvalid"}, 32'(tvalid), 32'd1);
    chk({tag, "_tdata"}, 32'(tdata), d);
    chk({tag, "_tuser"}, 32'(tuser), 32'(u));
    chk({tag, "_tlast"}, 32'(tlast), 32'(l));
  endtask

  task automatic idle(input string tag, input logic d, input logic b);
    @(negedge clk);
    chk({tag, "_tvalid"}, 32'(tvalid), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_busy"}, 32'(busy), 32'(b));
  endtask

  initial begin
    int k, cyc;
    rst_n = 0; en = 0; width = 4; height = 3; pattern = 1; color = 0; gap = 2; tready = 1;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 32'(tvalid), 0);
    chk("rst_tuser", 32'(tuser), 0);
    chk("rst_tlast", 32'(tlast), 0);
    chk("rst_tdata", 32'(tdata), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1;
    idle("no_enable", 0, 0);
    en = 1;
    for (int i = 0; i < 12; i++) beat("basic", ramp(i % 4), i == 0, i % 4 == 3);
    fc++;
    idle("basic_gap0", 1, 1);
    idle("basic_gap1", 0, 1);
    idle("basic_gap2", 0, 1);
    for (int i = 0; i < 12; i++) begin
      beat("disable", ramp(i % 4), i == 0, i % 4 == 3);
      if (i == 5) begin en = 0; width = 8; end
    end
    fc++;
    idle("dis_gap0", 1, 1);
    idle("dis_gap1", 0, 1);
    idle("dis_gap2", 0, 1);
    idle("dis_idle0", 0, 0);
    idle("dis_idle1", 0, 0);
    width = 4; height = 0; pattern = 2; en = 1;
    for (int i = 0; i < 3; i++) idle("zero_h", 0, 0);
    height = 2;
    for (int i = 0; i < 8; i++) begin
      beat("vramp", 32'(i / 4), i == 0, i % 4 == 3);
      if (i == 0) en = 0;
    end
    fc++;
    idle("vr_gap0", 1, 1);
    idle("vr_gap1", 0, 1);
    idle("vr_gap2", 0, 1);
    idle("vr_idle", 0, 0);
    width = 1; height = 1; pattern = 0; color = 24'hABCDEF; gap = 0; en = 1;
    beat("solid", 32'h00ABCDEF, 1, 1);
    en = 0; fc++;
    idle("solid_done", 1, 1);
    idle("gap_zero_exit", 0, 0);
    width = 16; height = 9; pattern = 3; en = 1;
    for (int i = 0; i < 144; i++) begin
      beat("checker", ((((i % 16) >> 3) ^ ((i / 16) >> 3)) & 1) != 0 ? 32'h00FFFFFF : 32'h0,
           i == 0, i % 16 == 15);
      if (i == 0) en = 0;
    end
    fc++;
    idle("chk_done", 1, 1);
    idle("chk_idle", 0, 0);
    width = 4; height = 3; pattern = 1; gap = 2; en = 1;
    k = 0; cyc = 0;
    while (k < 12 && cyc < 300) begin
      @(negedge clk);
      cyc++; en = 0;
      chk("bp_tvalid", 32'(tvalid), 1);
      chk("bp_tdata", 32'(tdata), ramp(k % 4));
      chk("bp_tuser", 32'(tuser), 32'(k == 0));
      chk("bp_tlast", 32'(tlast), 32'(k % 4 == 3));
      tready = 1'($urandom_range(0, 1));
      if (tvalid && tready) k++;
    end
    chk("bp_beats", 32'(k), 12);
    tready = 1; fc++;
    idle("bp_gap0", 1, 1);
    idle("bp_gap1", 0, 1);
    idle("bp_gap2", 0, 1);
    idle("bp_idle", 0, 0);
    en = 1;
    for (int i = 0; i < 7; i++) beat("pre_rst", ramp(i % 4), i == 0, i % 4 == 3);
    rst_n = 0;
    #1;
    chk("rst_mid_tvalid", 32'(tvalid), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    fc = 0;
    @(negedge clk);
    rst_n = 1;
    beat("post_rst", ramp(0), 1, 0);
    en = 0;
    for (int i = 1; i < 12; i++) beat("post_rst", ramp(i % 4), 0, i % 4 == 3);
    fc++;
    idle("post_gap0", 1, 1);
    idle("post_gap1", 0, 1);
    idle("post_gap2", 0, 1);
    idle("post_idle", 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
